// File: rtl/gpu_frame_reader.sv
// VGA scan-out reader: generates raster timing, fetches the stored grayscale
// image from memory, and drives the sync and pixel outputs through a 2-clock pipeline.
module gpu_frame_reader #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned IMG_W     = 256,
  parameter int unsigned IMG_H     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sel_decrypted,
  input  logic [7:0]  encrypted_gpu,
  input  logic [7:0]  decrypted_gpu,
  output logic [31:0] gpu_address,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_done
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);
  localparam int unsigned DivW   = $clog2(CLK_DIV);

  typedef enum logic [1:0] {StIdle, StArmed, StDisplay} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q;
  logic [HW-1:0]   hcount_q, hcount_d;
  logic [VW-1:0]   vcount_q, vcount_d;
  logic            tick, h_wrap, v_wrap;
  logic            tick_q1, tick_q2;
  logic [31:0]     hc, vc, hc_n, vc_n, addr_d;

  // Stage-1 flags (sampled one clock after the counter update)
  logic s1_hs, s1_vs, s1_vis, s1_img, s1_disp, s1_last;
  logic [7:0] pix_q;

  assign tick   = (div_q == DivW'(CLK_DIV - 1));
  assign h_wrap = (hcount_q == HW'(HTotal - 1));
  assign v_wrap = (vcount_q == VW'(VTotal - 1));
  assign hc     = 32'(hcount_q);
  assign vc     = 32'(vcount_q);
  assign hc_n   = 32'(hcount_d);
  assign vc_n   = 32'(vcount_d);

  // Next raster position and the address of the pixel it points at
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick) begin
      hcount_d = h_wrap ? '0 : hcount_q + HW'(1);
      if (h_wrap) vcount_d = v_wrap ? '0 : vcount_q + VW'(1);
    end
    if (hc_n < IMG_W && vc_n < IMG_H) addr_d = BASE_ADDR + vc_n * IMG_W + hc_n;
    else                              addr_d = BASE_ADDR;
  end

  // Display-enable FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StArmed;
      StArmed:   if (tick && h_wrap && v_wrap) state_d = StDisplay;
      StDisplay: state_d = StDisplay;
      default:   state_d = StIdle;
    endcase
  end

  // Timing counters, FSM and stage-1 address (address follows the new counter value)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      div_q       <= '0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      gpu_address <= BASE_ADDR;
      tick_q1     <= 1'b0;
      tick_q2     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= tick ? '0 : div_q + DivW'(1);
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      if (tick) gpu_address <= addr_d;
      tick_q1  <= tick;
      tick_q2  <= tick_q1;
    end
  end

  // Pipeline stage 1: decode sync/visibility for the current pixel
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      s1_vis  <= 1'b0;
      s1_img  <= 1'b0;
      s1_disp <= 1'b0;
      s1_last <= 1'b0;
    end else if (tick_q1) begin
      s1_hs   <= !(hc >= H_ACTIVE + H_FP && hc < H_ACTIVE + H_FP + H_SYNC);
      s1_vs   <= !(vc >= V_ACTIVE + V_FP && vc < V_ACTIVE + V_FP + V_SYNC);
      s1_vis  <= (hc < H_ACTIVE) && (vc < V_ACTIVE);
      s1_img  <= (hc < IMG_W) && (vc < IMG_H);
      s1_disp <= (state_q == StDisplay);
      s1_last <= (hc == H_ACTIVE - 1) && (vc == V_ACTIVE - 1);
    end
  end

  // Pipeline stage 2: capture memory data once per pixel so sel never glitches mid-pixel
  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      blank_n    <= 1'b0;
      pix_q      <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick_q2 && s1_disp && s1_last;
      if (tick_q2) begin
        hsync   <= s1_hs;
        vsync   <= s1_vs;
        blank_n <= s1_vis;
        pix_q   <= (s1_vis && s1_img && s1_disp) ?
                   (sel_decrypted ? decrypted_gpu : encrypted_gpu) : 8'h00;
      end
    end
  end

  assign red   = pix_q;
  assign green = pix_q;
  assign blue  = pix_q;

endmodule

// File: tb/tb_gpu_frame_reader.sv
// Directed bench for gpu_frame_reader on a reduced raster (24x12 total, 16x8 visible,
// 8x6 image, base 0x405). Pixel n = h + 24*v of the frame counted since reset release;
// its address is valid at cyc 2n and its outputs at cyc 2n+2.
module tb_gpu_frame_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sel_decrypted = 1'b0;
  logic [7:0]  encrypted_gpu = 8'h00;
  logic [7:0]  decrypted_gpu = 8'h00;
  logic [31:0] gpu_address;
  logic        hsync, vsync, blank_n, frame_done;
  logic [7:0]  red, green, blue;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  gpu_frame_reader #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .IMG_W(8), .IMG_H(6), .BASE_ADDR(32'h405)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sel_decrypted(sel_decrypted),
    .encrypted_gpu(encrypted_gpu), .decrypted_gpu(decrypted_gpu),
    .gpu_address(gpu_address), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .red(red), .green(green), .blue(blue), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Memory model: one-clock read latency
  always @(posedge clk) begin
    encrypted_gpu <= gpu_address[7:0];
    decrypted_gpu <= ~gpu_address[7:0];
  end

  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic goto(input int target);
    int guard = 0;
    @(negedge clk);
    while (cyc != target && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (cyc != target) begin
      $display("FAIL goto: cyc=%0d required=%0d", cyc, target);
      bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    repeat (4) @(negedge clk);
    total += 6;
    if (hsync !== 1'b1) begin $display("FAIL rst_hsync: got %b want 1", hsync); bad++; end
    if (vsync !== 1'b1) begin $display("FAIL rst_vsync: got %b want 1", vsync); bad++; end
    if (blank_n !== 1'b0) begin $display("FAIL rst_blank: got %b want 0", blank_n); bad++; end
    if (red !== 8'h00 || green !== 8'h00 || blue !== 8'h00) begin
      $display("FAIL rst_rgb: got %h/%h/%h want 00", red, green, blue); bad++;
    end
    if (gpu_address !== 32'h405) begin
      $display("FAIL rst_addr: got %h want 00000405", gpu_address); bad++;
    end
    if (frame_done !== 1'b0) begin $display("FAIL rst_fd: got %b want 0", frame_done); bad++; end
    start = 1'b0;
    rst = 1'b1;
  endtask

  // Frame 0 is idle: sync/blank counts over one frame, rgb stays 0
  task automatic test_timing();
    int hs_lo = 0, vs_lo = 0, bl_hi = 0, rgb_nz = 0, fd = 0;
    goto(9);
    repeat (576) begin
      @(negedge clk);
      if (!hsync) hs_lo++;
      if (!vsync) vs_lo++;
      if (blank_n) bl_hi++;
      if (red != 0 || green != 0 || blue != 0) rgb_nz++;
      if (frame_done) fd++;
      if (cyc == 37 || cyc == 38) begin
        total++;
        if (hsync !== (cyc == 37)) begin
          $display("FAIL hsync_edge: cyc=%0d got %b", cyc, hsync); bad++;
        end
      end
      if (cyc == 433 || cyc == 434) begin
        total++;
        if (vsync !== (cyc == 433)) begin
          $display("FAIL vsync_edge: cyc=%0d got %b", cyc, vsync); bad++;
        end
      end
    end
    total += 5;
    if (hs_lo != 96) begin $display("FAIL hsync_cnt: got %0d want 96", hs_lo); bad++; end
    if (vs_lo != 96) begin $display("FAIL vsync_cnt: got %0d want 96", vs_lo); bad++; end
    if (bl_hi != 256) begin $display("FAIL blank_cnt: got %0d want 256", bl_hi); bad++; end
    if (rgb_nz != 0) begin $display("FAIL idle_rgb: got %0d nonzero want 0", rgb_nz); bad++; end
    if (fd != 0) begin $display("FAIL idle_fd: got %0d pulses want 0", fd); bad++; end
  endtask

  // Arm mid-frame 1; display begins at frame 2 pixel (0,0)
  task automatic test_arming();
    int rgb_nz = 0, fd = 0;
    goto(700);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 1153) begin
      @(negedge clk);
      if (red != 0) rgb_nz++;
      if (frame_done) fd++;
    end
    total += 2;
    if (rgb_nz != 0) begin $display("FAIL armed_rgb: got %0d nonzero want 0", rgb_nz); bad++; end
    if (fd != 0) begin $display("FAIL armed_fd: got %0d want 0", fd); bad++; end
    @(negedge clk);
    total += 2;
    if (red !== 8'h05 || blue !== 8'h05) begin
      $display("FAIL first_px: got %h/%h want 05", red, blue); bad++;
    end
    if (blank_n !== 1'b1) begin $display("FAIL first_blank: got %b want 1", blank_n); bad++; end
    goto(1156);
    total++;
    if (red !== 8'h06) begin $display("FAIL second_px: got %h want 06", red); bad++; end
  endtask

  task automatic test_data();
    goto(1306);
    total++;
    if (gpu_address !== 32'h422) begin
      $display("FAIL addr_5_3: got %h want 00000422", gpu_address); bad++;
    end
    goto(1308);
    total++;
    if (red !== 8'h22 || green !== 8'h22 || blue !== 8'h22) begin
      $display("FAIL enc_5_3: got %h/%h/%h want 22", red, green, blue); bad++;
    end
    sel_decrypted = 1'b1;
    @(negedge clk);
    total++;
    if (red !== 8'h22) begin $display("FAIL no_glitch: got %h want 22", red); bad++; end
    @(negedge clk);
    total++;
    if (red !== 8'hDC || green !== 8'hDC || blue !== 8'hDC) begin
      $display("FAIL dec_6_3: got %h/%h/%h want dc", red, green, blue); bad++;
    end
    sel_decrypted = 1'b0;
    goto(1316);
    total++;
    if (gpu_address !== 32'h405) begin
      $display("FAIL addr_out: got %h want 00000405", gpu_address); bad++;
    end
    goto(1318);
    total++;
    if (red !== 8'h00 || blank_n !== 1'b1) begin
      $display("FAIL px_out: got rgb=%h blank=%b want 00/1", red, blank_n); bad++;
    end
    goto(1406);
    total++;
    if (gpu_address !== 32'h434) begin
      $display("FAIL addr_7_5: got %h want 00000434", gpu_address); bad++;
    end
    goto(1408);
    total += 2;
    if (red !== 8'h34) begin $display("FAIL px_7_5: got %h want 34", red); bad++; end
    if (gpu_address !== 32'h405) begin
      $display("FAIL addr_8_5: got %h want 00000405", gpu_address); bad++;
    end
    goto(1448);
    total++;
    if (red !== 8'h00 || blank_n !== 1'b1) begin
      $display("FAIL px_3_6: got rgb=%h blank=%b want 00/1", red, blank_n); bad++;
    end
  endtask

  // frame_done once per displayed frame; start ignored while displaying
  task automatic test_back_to_back();
    int fd = 0, first = -1;
    while (cyc < 2880) begin
      @(negedge clk);
      if (cyc == 2000) start = 1'b1;
      if (cyc == 2001) start = 1'b0;
      if (frame_done) begin
        fd++;
        if (first < 0) first = cyc;
      end
      if (cyc == 1730) begin
        total++;
        if (red !== 8'h05) begin $display("FAIL frame3_px: got %h want 05", red); bad++; end
      end
    end
    total += 2;
    if (fd != 3) begin $display("FAIL fd_count: got %0d want 3", fd); bad++; end
    if (first != 1520) begin $display("FAIL fd_cycle: got %0d want 1520", first); bad++; end
  endtask

  task automatic test_reset_mid();
    int rgb_nz = 0, fd = 0;
    goto(3130);
    total++;
    if (red !== 8'h31) begin $display("FAIL pre_rst_px: got %h want 31", red); bad++; end
    rst = 1'b0;
    @(negedge clk);
    total += 5;
    if (red !== 8'h00 || green !== 8'h00 || blue !== 8'h00) begin
      $display("FAIL mid_rst_rgb: got %h want 00", red); bad++;
    end
    if (hsync !== 1'b1 || vsync !== 1'b1) begin
      $display("FAIL mid_rst_sync: got %b%b want 11", hsync, vsync); bad++;
    end
    if (blank_n !== 1'b0) begin $display("FAIL mid_rst_blank: got %b want 0", blank_n); bad++; end
    if (gpu_address !== 32'h405) begin
      $display("FAIL mid_rst_addr: got %h want 00000405", gpu_address); bad++;
    end
    if (frame_done !== 1'b0) begin $display("FAIL mid_rst_fd: got %b want 0", frame_done); bad++; end
    rst = 1'b1;
    repeat (1200) begin
      @(negedge clk);
      if (red != 0) rgb_nz++;
      if (frame_done) fd++;
    end
    total += 2;
    if (rgb_nz != 0) begin $display("FAIL post_rst_rgb: got %0d nonzero want 0", rgb_nz); bad++; end
    if (fd != 0) begin $display("FAIL post_rst_fd: got %0d want 0", fd); bad++; end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_arming();
    test_data();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
